// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : Frame receiver: start bit (0), DATA_WIDTH bits MSB first, stop bit
//            (1). Produces a valid pulse per word and a frame_err pulse.
//            Optional macro UART_RX_SYNC_EN adds a two-flop rx synchronizer.
// Revision : 1.0
// ============================================================================
module uart_receiver #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int c_BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam int c_HALF   = (CLKS_PER_BIT - 1) / 2;

    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_HALF = c_BAUD_W'(c_HALF);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic                  w_rx;
    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [c_BIT_W-1:0]    r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  w_baud_hit;
    logic                  w_half_hit;
    logic                  w_valid_set;
    logic                  w_ferr_set;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = rx;
`endif

    // r_baud holds the 1-based offset of the current cycle within a bit period
    assign w_baud_hit = (r_baud == c_BAUD_LAST);
    assign w_half_hit = (r_baud == c_BAUD_HALF);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rx) begin
                    w_next = (c_HALF == 0) ? S_DATA : S_START;
                end
            end
            S_START: begin
                if (w_half_hit) begin
                    w_next = w_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_hit && (r_bit == c_BIT_LAST)) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_hit) begin
                    w_next = w_rx ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (w_rx) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        w_valid_set = (r_state == S_STOP) && w_baud_hit && w_rx;
        w_ferr_set  = (r_state == S_STOP) && w_baud_hit && !w_rx;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            r_shift   <= '0;
            r_baud    <= '0;
            r_bit     <= '0;
        end else begin
            valid     <= w_valid_set;
            frame_err <= w_ferr_set;
            if (w_valid_set) begin
                data <= r_shift;
            end
            case (r_state)
                S_IDLE: begin
                    r_baud <= c_BAUD_ONE;
                    r_bit  <= '0;
                end
                S_START: begin
                    r_baud <= w_half_hit ? c_BAUD_ONE : r_baud + c_BAUD_ONE;
                end
                S_DATA: begin
                    if (w_baud_hit) begin
                        r_shift <= DATA_WIDTH'({r_shift, w_rx});
                        r_baud  <= c_BAUD_ONE;
                        r_bit   <= r_bit + c_BIT_ONE;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (!w_baud_hit) begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Brief    : Self-checking bench; a frame-level reference model predicts busy,
//            frame_err, valid and data for every cycle of each line waveform.
// Revision : 1.0
// ============================================================================
module tb_uart_receiver;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int MAXN = 1024;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic       rx_a  = 1'b1;
    logic       rx_b  = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

    uart_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut_a (
        .CLK(CLK), .RESET(RESET), .rx(rx_a), .data(data_a),
        .valid(valid_a), .frame_err(ferr_a), .busy(busy_a)
    );

    uart_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut_b (
        .CLK(CLK), .RESET(RESET), .rx(rx_b), .data(data_b),
        .valid(valid_b), .frame_err(ferr_b), .busy(busy_b)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    logic       line [MAXN];
    int         wp;
    bit         eb [MAXN];
    bit         ev [MAXN];
    bit         ef [MAXN];
    logic [7:0] ew [MAXN];
    logic [7:0] ed [MAXN];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;

    task automatic put_level(input logic v, input int n);
        for (int k = 0; k < n; k++) begin
            line[wp] = v;
            wp++;
        end
    endtask

    task automatic put_frame(input logic [7:0] w, input int cpb, input logic stop);
        put_level(1'b0, cpb);
        for (int k = 7; k >= 0; k--) put_level(w[k], cpb);
        put_level(stop, cpb);
    endtask

    // Line as seen by the receiver's sampling logic (optionally delayed).
    function automatic logic eff(input int i);
        int j;
        j = i - LAT;
        if (j < 0 || j >= wp) return 1'b1;
        return line[j];
    endfunction

    // Walks the waveform frame by frame using the sample-point arithmetic.
    task automatic model_run(input int cpb, input logic [7:0] d0);
        int         i, h, t0, s;
        bit         whigh;
        logic [7:0] w, dcur;
        for (int j = 0; j < wp; j++) begin
            eb[j] = 0; ev[j] = 0; ef[j] = 0; ew[j] = 8'h00;
        end
        h = (cpb - 1) / 2;
        i = 0;
        whigh = 0;
        while (i < wp) begin
            if (whigh) begin
                eb[i] = 1;
                if (eff(i)) whigh = 0;
                i++;
            end else if (!eff(i)) begin
                t0 = i;
                if (h > 0 && eff(t0 + h)) begin
                    for (int j = t0 + 1; j <= t0 + h && j < wp; j++) eb[j] = 1;
                    i = t0 + h + 1;
                end else begin
                    w = 8'h00;
                    for (int k = 0; k < 8; k++) w = {w[6:0], eff(t0 + h + (k + 1) * cpb)};
                    s = t0 + h + 9 * cpb;
                    for (int j = t0 + 1; j <= s && j < wp; j++) eb[j] = 1;
                    if (s + 1 < wp) begin
                        if (eff(s)) begin
                            ev[s + 1] = 1;
                            ew[s + 1] = w;
                        end else begin
                            ef[s + 1] = 1;
                        end
                    end
                    whigh = !eff(s);
                    i = s + 1;
                end
            end else begin
                i++;
            end
        end
        dcur = d0;
        for (int j = 0; j < wp; j++) begin
            if (ev[j]) dcur = ew[j];
            ed[j] = dcur;
        end
    endtask

    function automatic logic [10:0] expv(input int i);
        return {eb[i], ef[i], ev[i], ed[i]};
    endfunction

    // Drives one line cycle and samples {busy, frame_err, valid, data} mid-cycle.
    task automatic step(input bit sel, input logic v, output logic [10:0] obs);
        if (sel) rx_b = v; else rx_a = v;
        @(negedge CLK);
        obs = sel ? {busy_b, ferr_b, valid_b, data_b} : {busy_a, ferr_a, valid_a, data_a};
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        checks++;
        if ({busy_a, ferr_a, valid_a, data_a} !== 11'h000) begin
            errors++;
            $display("FAIL reset_a: got %h expected 000", {busy_a, ferr_a, valid_a, data_a});
        end
        checks++;
        if ({busy_b, ferr_b, valid_b, data_b} !== 11'h000) begin
            errors++;
            $display("FAIL reset_b: got %h expected 000", {busy_b, ferr_b, valid_b, data_b});
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        last_a = 8'h00;
        last_b = 8'h00;
    endtask

    task automatic test_single_frame;
        logic [10:0] obs;
        wp = 0;
        put_level(1'b1, 20);
        put_frame(8'hA5, 1, 1'b1);
        put_level(1'b1, 15);
        model_run(1, last_a);
        for (int i = 0; i < wp; i++) begin
            step(0, line[i], obs);
            checks++;
            if (obs !== expv(i)) begin
                errors++;
                $display("FAIL single cycle %0d: got %h expected %h", i, obs, expv(i));
            end
            if (i == 30 + LAT) begin
                checks++;
                if (obs[8:0] !== 9'h1A5) begin
                    errors++;
                    $display("FAIL single_valid_at_30: got valid/data %h expected 1a5", obs[8:0]);
                end
            end
        end
        last_a = ed[wp - 1];
    endtask

    task automatic test_back_to_back;
        logic [10:0] obs;
        int          npulse, first, second;
        wp = 0;
        put_level(1'b1, 4);
        put_frame(8'h3C, 1, 1'b1);
        put_frame(8'hC3, 1, 1'b1);
        put_frame(8'($urandom), 1, 1'b1);
        put_frame(8'($urandom), 1, 1'b1);
        put_level(1'b1, 12);
        model_run(1, last_a);
        npulse = 0; first = -1; second = -1;
        for (int i = 0; i < wp; i++) begin
            step(0, line[i], obs);
            checks++;
            if (obs !== expv(i)) begin
                errors++;
                $display("FAIL b2b cycle %0d: got %h expected %h", i, obs, expv(i));
            end
            if (obs[8]) begin
                npulse++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        checks++;
        if (npulse !== 4) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d expected 4", npulse);
        end
        checks++;
        if (second - first !== 10) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected 10", second - first);
        end
        last_a = ed[wp - 1];
    endtask

    task automatic test_frame_error;
        logic [10:0] obs;
        logic [7:0]  prev;
        int          nvalid;
        prev = last_a;
        wp = 0;
        put_level(1'b1, 4);
        put_frame(8'hFF, 1, 1'b0);
        put_level(1'b0, 5);
        put_level(1'b1, 3);
        put_frame(8'h81, 1, 1'b1);
        put_level(1'b1, 12);
        model_run(1, last_a);
        nvalid = 0;
        for (int i = 0; i < wp; i++) begin
            step(0, line[i], obs);
            checks++;
            if (obs !== expv(i)) begin
                errors++;
                $display("FAIL ferr cycle %0d: got %h expected %h", i, obs, expv(i));
            end
            if (obs[8]) nvalid++;
            if (i == 14 + LAT) begin
                checks++;
                if (obs[9:0] !== {2'b10, prev}) begin
                    errors++;
                    $display("FAIL ferr_pulse: got ferr/valid/data %h expected %h", obs[9:0], {2'b10, prev});
                end
            end
        end
        checks++;
        if (nvalid !== 1 || data_a !== 8'h81) begin
            errors++;
            $display("FAIL ferr_recovery: got %0d valids data %h expected 1 valid data 81", nvalid, data_a);
        end
        last_a = ed[wp - 1];
    endtask

    task automatic test_glitch_slow;
        logic [10:0] obs;
        int          t0;
        wp = 0;
        put_level(1'b1, 8);
        put_level(1'b0, 1);
        put_level(1'b1, 10);
        t0 = wp;
        put_frame(8'h5A, 4, 1'b1);
        put_level(1'b1, 12);
        model_run(4, last_b);
        for (int i = 0; i < wp; i++) begin
            step(1, line[i], obs);
            checks++;
            if (obs !== expv(i)) begin
                errors++;
                $display("FAIL glitch cycle %0d: got %h expected %h", i, obs, expv(i));
            end
            if (i < t0 + LAT && obs[8]) begin
                checks++;
                errors++;
                $display("FAIL glitch_no_valid: got valid=1 at cycle %0d expected 0", i);
            end
            if (i == t0 + 38 + LAT) begin
                checks++;
                if (obs[8:0] !== 9'h15A) begin
                    errors++;
                    $display("FAIL slow_valid_at_t0_38: got valid/data %h expected 15a", obs[8:0]);
                end
            end
        end
        last_b = ed[wp - 1];
    endtask

    task automatic test_reset_midframe;
        logic [10:0] obs;
        wp = 0;
        put_level(1'b1, 4);
        put_frame(8'h96, 1, 1'b1);
        for (int i = 0; i < 9; i++) step(0, line[i], obs);
        RESET = 1'b1;
        step(0, line[9], obs);
        RESET = 1'b0;
        last_a = 8'h00;
        last_b = 8'h00;
        wp = 0;
        put_level(1'b1, 6);
        put_frame(8'h69, 1, 1'b1);
        put_level(1'b1, 12);
        model_run(1, 8'h00);
        for (int i = 0; i < wp; i++) begin
            step(0, line[i], obs);
            checks++;
            if (obs !== expv(i)) begin
                errors++;
                $display("FAIL rst_mid cycle %0d: got %h expected %h", i, obs, expv(i));
            end
            if (i < 6) begin
                checks++;
                if (obs !== 11'h000) begin
                    errors++;
                    $display("FAIL rst_mid_outputs cycle %0d: got %h expected 000", i, obs);
                end
            end
        end
        checks++;
        if (data_a !== 8'h69) begin
            errors++;
            $display("FAIL rst_mid_next_frame: got %h expected 69", data_a);
        end
        last_a = ed[wp - 1];
    endtask

    task automatic test_random;
        logic [10:0] obs;
        wp = 0;
        put_level(1'b1, 3);
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                put_frame(8'($urandom), 1, 1'b0);
                put_level(1'b0, $urandom_range(0, 3));
                put_level(1'b1, $urandom_range(1, 3));
            end else begin
                put_frame(8'($urandom), 1, 1'b1);
                put_level(1'b1, $urandom_range(0, 3));
            end
        end
        put_level(1'b1, 12);
        model_run(1, last_a);
        for (int i = 0; i < wp; i++) begin
            step(0, line[i], obs);
            checks++;
            if (obs !== expv(i)) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, expv(i));
            end
        end
        last_a = ed[wp - 1];
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_frame_error();
        test_glitch_slow();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
